// File: rtl/control_sequencer.sv
// Control sequencer: fetches one instruction over a handshaked memory read and then
// steps the datapath strobes for the decoded op class. Outputs are Moore outputs
// decoded from the state register and the IR contents.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic        mem_rdy,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        memRead,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FIN
    } state_t;

    typedef enum logic [1:0] {
        CLS_TWO, CLS_MD, CLS_UN, CLS_ILL
    } op_class_t;

    // Maps an op code to the execution sequence it needs.
    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: classify = CLS_TWO;
            5'b01111, 5'b10000:                     classify = CLS_MD;
            5'b10001, 5'b10010:                     classify = CLS_UN;
            default:                                classify = CLS_ILL;
        endcase
    endfunction

    state_t    state_q, state_d;
    op_class_t cls;
    logic [4:0] op;
    logic [15:0] ra_oh, rb_oh, rc_oh;
    logic unused_ir_bits;

    assign op             = ir[31:27];
    assign ra_oh          = 16'd1 << ir[26:23];
    assign rb_oh          = 16'd1 << ir[22:19];
    assign rc_oh          = 16'd1 << ir[18:15];
    assign cls            = classify(op);
    assign unused_ir_bits = ^ir[14:0];

    // State register; clear returns to IDLE regardless of run or mem_rdy.
    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and strobe decode; everything defaults low so each state only names its strobes.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        memRead  = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = 16'd0;
        Rout     = 16'd0;
        alu_op   = 5'd0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_T0;
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                memRead = 1'b1;
                MDRin   = 1'b1;
                if (mem_rdy) state_d = S_T2;
            end
            S_T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                alu_op = op;
                case (cls)
                    CLS_TWO: begin Rout = rb_oh; Yin = 1'b1; state_d = S_T4; end
                    CLS_MD:  begin Rout = ra_oh; Yin = 1'b1; state_d = S_T4; end
                    CLS_UN:  begin Rout = rb_oh; Zin = 1'b1; state_d = S_T4; end
                    default: begin illegal = 1'b1;            state_d = S_IDLE; end
                endcase
            end
            S_T4: begin
                alu_op = op;
                case (cls)
                    CLS_TWO: begin Rout = rc_oh; Zin = 1'b1; state_d = S_T5; end
                    CLS_MD:  begin Rout = rb_oh; Zin = 1'b1; state_d = S_T5; end
                    CLS_UN:  begin Zlowout = 1'b1; Rin = ra_oh; state_d = S_FIN; end
                    default: state_d = S_IDLE;
                endcase
            end
            S_T5: begin
                alu_op  = op;
                Zlowout = 1'b1;
                if (cls == CLS_MD) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = ra_oh;
                    state_d = S_FIN;
                end
            end
            S_T6: begin
                alu_op   = op;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_FIN;
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a driver issues instructions and queues the expected
// per-cycle strobe trace; a monitor records the DUT trace and compares on done/illegal.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear, run, mem_rdy;
    logic [31:0] ir;
    logic        PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin, Yin, Zin;
    logic        Zlowout, Zhighout, HIin, LOin, done, illegal;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;

    control_sequencer dut (
        .clock(clock), .clear(clear), .run(run), .mem_rdy(mem_rdy), .ir(ir),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .memRead(memRead),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in;
        logic        y_in, z_in, zlo_out, zhi_out, hi_in, lo_in;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        done;
        logic        illegal;
    } ow_t;

    typedef struct {
        ow_t w [0:15];
        int  n;
    } exp_t;

    exp_t sb[$];
    ow_t  tr[$];
    int   checks = 0;
    int   errors = 0;
    int   completions = 0;
    bit   mon_en = 0;
    bit   recording = 0;

    logic [4:0] ops [12] = '{5'b00011, 5'b00100, 5'b00101, 5'b00111, 5'b01000, 5'b01001,
                             5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b10001, 5'b10010};

    function automatic ow_t cur_out();
        ow_t o;
        o = '{pc_out: PCout, mar_in: MARin, inc_pc: IncPC, mem_read: memRead,
              mdr_in: MDRin, mdr_out: MDRout, ir_in: IRin, y_in: Yin, z_in: Zin,
              zlo_out: Zlowout, zhi_out: Zhighout, hi_in: HIin, lo_in: LOin,
              rin: Rin, rout: Rout, alu: alu_op, done: done, illegal: illegal};
        return o;
    endfunction

    function automatic void add(inout exp_t e, input ow_t w);
        e.w[e.n] = w;
        e.n = e.n + 1;
    endfunction

    // Reference: the cycle-by-cycle strobe list the instruction should produce.
    function automatic exp_t build(input logic [31:0] v, input int wt);
        exp_t e;
        ow_t  w;
        logic [4:0] op = v[31:27];
        logic [15:0] ra = 16'd1 << v[26:23];
        logic [15:0] rb = 16'd1 << v[22:19];
        logic [15:0] rc = 16'd1 << v[18:15];
        int kind;
        e.n = 0;
        w = '0; w.pc_out = 1; w.mar_in = 1; w.inc_pc = 1; add(e, w);
        for (int i = 0; i <= wt; i++) begin
            w = '0; w.mem_read = 1; w.mdr_in = 1; add(e, w);
        end
        w = '0; w.mdr_out = 1; w.ir_in = 1; add(e, w);
        kind = 3;
        for (int i = 0; i < 12; i++)
            if (ops[i] == op) kind = (i < 8) ? 0 : (i < 10) ? 1 : 2;
        case (kind)
            0: begin
                w = '0; w.alu = op; w.rout = rb; w.y_in = 1; add(e, w);
                w = '0; w.alu = op; w.rout = rc; w.z_in = 1; add(e, w);
                w = '0; w.alu = op; w.zlo_out = 1; w.rin = ra; add(e, w);
            end
            1: begin
                w = '0; w.alu = op; w.rout = ra; w.y_in = 1; add(e, w);
                w = '0; w.alu = op; w.rout = rb; w.z_in = 1; add(e, w);
                w = '0; w.alu = op; w.zlo_out = 1; w.lo_in = 1; add(e, w);
                w = '0; w.alu = op; w.zhi_out = 1; w.hi_in = 1; add(e, w);
            end
            2: begin
                w = '0; w.alu = op; w.rout = rb; w.z_in = 1; add(e, w);
                w = '0; w.alu = op; w.zlo_out = 1; w.rin = ra; add(e, w);
            end
            default: begin
                w = '0; w.alu = op; w.illegal = 1; add(e, w);
            end
        endcase
        if (kind != 3) begin
            w = '0; w.done = 1; add(e, w);
        end
        return e;
    endfunction

    // Monitor: per-cycle invariants, trace capture, and scoreboard comparison.
    always @(negedge clock) begin
        ow_t  c;
        exp_t e;
        int   bad;
        c = cur_out();
        if (mon_en && clear) begin
            recording = 0;
            tr.delete();
        end else if (mon_en) begin
            checks++;
            if (!$onehot0(Rin) || !$onehot0(Rout) || (Rin != 0 && Rout != 0) ||
                $countones({MDRout, PCout, Zlowout, Zhighout, Rout}) > 1 || (done && illegal)) begin
                errors++;
                $display("FAIL invariant t=%0t Rin=%h Rout=%h drivers=%b done=%b illegal=%b",
                         $time, Rin, Rout, {MDRout, PCout, Zlowout, Zhighout}, done, illegal);
            end
            if (!recording && c != '0) recording = 1;
            if (recording) tr.push_back(c);
            if (c.done || c.illegal) begin
                completions++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_end got trace of %0d cycles, required no completion", tr.size());
                end else begin
                    e = sb.pop_front();
                    bad = -1;
                    if (e.n != tr.size()) bad = 99;
                    else
                        for (int i = e.n - 1; i >= 0; i--)
                            if (tr[i] != e.w[i]) bad = i;
                    if (bad == 99) begin
                        errors++;
                        $display("FAIL trace_len got %0d cycles, required %0d", tr.size(), e.n);
                    end else if (bad >= 0) begin
                        errors++;
                        $display("FAIL trace cycle %0d got %h, required %h", bad, tr[bad], e.w[bad]);
                    end
                end
                recording = 0;
                tr.delete();
            end
        end
    end

    task automatic check_zero(input string name);
        @(negedge clock);
        checks++;
        if (cur_out() != '0) begin
            errors++;
            $display("FAIL %s outputs got %h, required 0", name, cur_out());
        end
    endtask

    task automatic issue(input logic [31:0] v, input int wt);
        int c0;
        bit got;
        sb.push_back(build(v, wt));
        ir = v;
        run = 1;
        mem_rdy = (wt == 0);
        c0 = completions;
        @(posedge clock); #1;
        run = 0;
        if (wt > 0) begin
            for (int i = 0; i <= wt; i++) begin
                @(posedge clock); #1;
                run = 1'($urandom_range(0, 1));
            end
            run = 0;
            mem_rdy = 1;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clock); #1;
            if (completions != c0) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout ir=%h got no done/illegal, required one", v);
            sb.delete();
            clear = 1;
            @(posedge clock); #1;
            clear = 0;
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [4:0]  op;
        clear = 1; run = 0; mem_rdy = 0; ir = '0;
        repeat (2) @(posedge clock);
        #1;
        clear = 0;
        mon_en = 1;
        check_zero("reset");
        check_zero("idle_no_run");

        issue(32'h5091_8000, 0);                                   // AND r1 <- r2 & r3
        issue({5'b00011, 4'd7, 4'd2, 4'd9, 15'd0}, 3);             // ADD, 3-cycle fetch wait
        issue({5'b01111, 4'd4, 4'd5, 4'd6, 15'h1234}, 0);          // MUL
        issue({5'b10000, 4'd15, 4'd0, 4'd1, 15'd0}, 1);            // DIV
        issue({5'b10001, 4'd0, 4'd15, 4'd3, 15'd0}, 0);            // NEG
        issue({5'b10010, 4'd8, 4'd9, 4'd10, 15'd0}, 2);            // NOT
        issue({5'b11111, 4'd1, 4'd2, 4'd3, 15'd0}, 0);             // illegal
        check_zero("after_illegal");
        issue({5'b00000, 4'd1, 4'd2, 4'd3, 15'd0}, 1);             // illegal low code

        // clear during T4 of an ADD
        ir = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};
        run = 1; mem_rdy = 1;
        @(posedge clock); #1;
        run = 0;
        repeat (4) @(posedge clock);
        #1;
        clear = 1;
        @(posedge clock); #1;
        clear = 0;
        check_zero("clear_in_t4");
        issue({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0}, 0);

        // clear during a T1 wait, together with run and mem_rdy
        run = 1; mem_rdy = 0;
        @(posedge clock); #1;
        run = 0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1; run = 1; mem_rdy = 1;
        @(posedge clock); #1;
        clear = 0; run = 0;
        check_zero("clear_priority");

        // clear pulse with run low leaves the block idle
        clear = 1;
        @(posedge clock); #1;
        clear = 0;
        repeat (3) check_zero("idle_hold");
        #1;

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 11)];
            else                          op = 5'($urandom_range(0, 31));
            v = $urandom;
            v[31:27] = op;
            issue(v, $urandom_range(0, 4));
        end

        check_zero("final_idle");
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
